// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared arithmetic definitions: operation encoding and a parameter sanity check
// for the segmented carry-lookahead adder/subtractor.
package arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // True when WIDTH splits into STAGES segments that each hold whole lookahead groups.
    function automatic bit cfg_ok(input int width, input int block, input int stages);
        if (block < 1 || stages < 1 || width < 1) return 1'b0;
        if ((width % (stages * block)) != 0) return 1'b0;
        return stages <= (width / block);
    endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op_sub, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op_sub, cin, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub_cla_group.sv
// Combinational BLOCK-bit carry-lookahead group; exports group propagate and
// generate so a second lookahead level can form carries between groups.
module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             gp,
    output logic             gg
);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] c;
    logic             term;

    assign p   = a ^ b;
    assign g   = a & b;
    assign gp  = &p;
    assign sum = p ^ c;

    // Each carry is a flat sum of products of g/p terms, never a chain of c[i-1].
    always_comb begin
        c    = '0;
        gg   = 1'b0;
        term = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            term = cin;
            for (int n = 0; n < i; n++) term = term & p[n];
            c[i] = term;
            for (int m = 0; m < i; m++) begin
                term = g[m];
                for (int n = m + 1; n < i; n++) term = term & p[n];
                c[i] = c[i] | term;
            end
        end
        for (int m = 0; m < BLOCK; m++) begin
            term = g[m];
            for (int n = m + 1; n < BLOCK; n++) term = term & p[n];
            gg = gg | term;
        end
    end
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES segment resolved per
// stage, carry and skew (unresolved operands, resolved sum bits) registered between stages.
module pipelined_cla_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / BLOCK;

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : gen_cfg_err
        $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK");
    end

    logic adv;

    // The whole pipe moves as one; bubbles are not collapsed.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    genvar gi, gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : gen_stage
            localparam int LO = gi * SEG;
            localparam int HI = LO + SEG;

            logic [WIDTH-LO-1:0] src_a;
            logic [WIDTH-LO-1:0] src_b;
            logic                src_cin;
            logic                src_valid;
            logic [SEG-1:0]      seg_a;
            logic [SEG-1:0]      seg_b;
            logic [SEG-1:0]      seg_sum;
            logic [NG-1:0]       grp_p;
            logic [NG-1:0]       grp_g;
            logic [NG:0]         grp_c;
            logic                term;
            logic [HI-1:0]       sum_next;
            logic                valid_reg;
            logic                carry_reg;
            logic [HI-1:0]       sum_reg;

            if (gi == 0) begin : gen_src
                // b is inverted once here; later stages receive the already-effective operand.
                assign src_a     = bus.a;
                assign src_b     = bus.b ^ {WIDTH{bus.op_sub}};
                assign src_cin   = (bus.op_sub == OP_SUB) ? 1'b1 : bus.cin;
                assign src_valid = bus.in_valid;
                assign sum_next  = seg_sum;
            end else begin : gen_src
                assign src_a     = gen_stage[gi-1].gen_keep.a_rem_reg;
                assign src_b     = gen_stage[gi-1].gen_keep.b_rem_reg;
                assign src_cin   = gen_stage[gi-1].carry_reg;
                assign src_valid = gen_stage[gi-1].valid_reg;
                assign sum_next  = {seg_sum, gen_stage[gi-1].sum_reg};
            end

            assign seg_a = src_a[SEG-1:0];
            assign seg_b = src_b[SEG-1:0];

            for (gj = 0; gj < NG; gj++) begin : gen_grp
                cla_group #(.BLOCK(BLOCK)) u_grp (
                    .a   (seg_a[gj*BLOCK +: BLOCK]),
                    .b   (seg_b[gj*BLOCK +: BLOCK]),
                    .cin (grp_c[gj]),
                    .sum (seg_sum[gj*BLOCK +: BLOCK]),
                    .gp  (grp_p[gj]),
                    .gg  (grp_g[gj])
                );
            end

            // Second-level lookahead across the groups of this segment.
            always_comb begin
                grp_c = '0;
                term  = 1'b0;
                for (int j = 0; j <= NG; j++) begin
                    term = src_cin;
                    for (int n = 0; n < j; n++) term = term & grp_p[n];
                    grp_c[j] = term;
                    for (int m = 0; m < j; m++) begin
                        term = grp_g[m];
                        for (int n = m + 1; n < j; n++) term = term & grp_p[n];
                        grp_c[j] = grp_c[j] | term;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else if (adv) begin
                    valid_reg <= src_valid;
                    carry_reg <= grp_c[NG];
                    sum_reg   <= sum_next;
                end
            end

            if (gi < STAGES - 1) begin : gen_keep
                logic [WIDTH-HI-1:0] a_rem_reg;
                logic [WIDTH-HI-1:0] b_rem_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_rem_reg <= '0;
                        b_rem_reg <= '0;
                    end else if (adv) begin
                        a_rem_reg <= src_a[WIDTH-LO-1:SEG];
                        b_rem_reg <= src_b[WIDTH-LO-1:SEG];
                    end
                end
            end else begin : gen_last
                logic msb_c;
                logic ovf_reg;
                logic zero_reg;

                // Carry into the MSB recovered from its sum bit and propagate term.
                assign msb_c = seg_sum[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg  <= 1'b0;
                        zero_reg <= 1'b0;
                    end else if (adv) begin
                        ovf_reg  <= msb_c ^ grp_c[NG];
                        zero_reg <= ~|sum_next;
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = gen_stage[STAGES-1].valid_reg;
    assign bus.sum       = gen_stage[STAGES-1].sum_reg;
    assign bus.cout      = gen_stage[STAGES-1].carry_reg;
    assign bus.ovf       = gen_stage[STAGES-1].gen_last.ovf_reg;
    assign bus.zero      = gen_stage[STAGES-1].gen_last.zero_reg;
endmodule
